// File: rtl/yc_pkg.sv
// Shared types, widths, default levels and the 8-bit clamp for the Y/C to CVBS mixer.
package yc_pkg;

  localparam int unsigned DW       = 8;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned CS_W     = 10;
  localparam int unsigned SUM_W    = 11;
  localparam int unsigned YPROD_W  = 2 * DW;
  localparam int unsigned CPROD_W  = 2 * DW + 2;
  localparam int unsigned PIPE_LAT = 3;

  localparam logic [DW-1:0]    SYNC_LVL_DEF  = 8'd0;
  localparam logic [DW-1:0]    BLANK_LVL_DEF = 8'd64;
  localparam logic [DW-1:0]    SETUP_LVL_DEF = 8'd10;
  localparam logic [DW-1:0]    Y_GAIN_DEF    = 8'd176;
  localparam logic [DW-1:0]    C_GAIN_DEF    = 8'd128;
  localparam logic [CNT_W-1:0] BP_CLKS_DEF   = 11'd100;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_PORCH  = 2'd2,
    ST_ACTIVE = 2'd3
  } yc_state_e;

  // Scaled pixel carried from the scale stage to the sum/clamp stage.
  typedef struct packed {
    logic [DW-1:0]   y_scl;
    logic [CS_W-1:0] cs_scl;
    logic            pal_en;
    logic            vblank;
  } yc_s2_t;

  localparam logic signed [SUM_W-1:0] CLAMP_MAX = 11'sd255;
  localparam logic signed [SUM_W-1:0] C_MID     = 11'sd128;

  function automatic logic [DW-1:0] clamp8(input logic signed [SUM_W-1:0] v);
    logic [DW-1:0] r;
    if (v[SUM_W-1]) begin
      r = '0;
    end else if (v > CLAMP_MAX) begin
      r = '1;
    end else begin
      r = DW'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/yc_sync_tracker.sv
// Line-timing tracker: csync edge detect, WAIT/SYNC/PORCH/ACTIVE FSM and saturating porch counter.
// state_o is registered and lines up with the pixel held in the scale stage.
module yc_sync_tracker
  import yc_pkg::*;
#(
  parameter logic [CNT_W-1:0] BP_CLKS = BP_CLKS_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      csync_i,
  output yc_state_e state_o
);

  localparam logic [CNT_W-1:0] BP_LAST = CNT_W'(BP_CLKS - CNT_W'(1));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  yc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             csync_prev_q;
  logic             rise_c, fall_c;

  assign rise_c = csync_i & ~csync_prev_q;
  assign fall_c = ~csync_i & csync_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      csync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      csync_prev_q <= csync_i;
    end
  end

  // A csync rise takes priority over porch expiry in every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: begin
        if (rise_c) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        cnt_d = '0;
        if (fall_c) state_d = ST_PORCH;
      end
      ST_PORCH: begin
        if (rise_c) begin
          state_d = ST_SYNC;
        end else if (cnt_q == BP_LAST) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (rise_c) state_d = ST_SYNC;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/yc_cvbs_mix.sv
// Y/C to DAC-code mixer: inserts sync tip, blanking and NTSC setup, produces CVBS and S-video codes.
// Three-stage pipeline (register/edge detect, scale, sum/clamp); syncs are delayed to match.
module yc_cvbs_mix
  import yc_pkg::*;
#(
  parameter logic [DW-1:0]    SYNC_LVL  = SYNC_LVL_DEF,
  parameter logic [DW-1:0]    BLANK_LVL = BLANK_LVL_DEF,
  parameter logic [DW-1:0]    SETUP_LVL = SETUP_LVL_DEF,
  parameter logic [DW-1:0]    Y_GAIN    = Y_GAIN_DEF,
  parameter logic [DW-1:0]    C_GAIN    = C_GAIN_DEF,
  parameter logic [CNT_W-1:0] BP_CLKS   = BP_CLKS_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pal_en,
  input  logic [DW-1:0] y_in,
  input  logic [DW-1:0] c_in,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          csync,
  input  logic          vblank,
  output logic [DW-1:0] cvbs,
  output logic [DW-1:0] luma_s,
  output logic [DW-1:0] chroma_s,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          csync_o
);

  // Stage 1 registers; bit 0 of the sync delay lines doubles as the stage-1 sync sample.
  logic [DW-1:0]       y1_q, c1_q;
  logic                pal1_q, vblank1_q;
  logic [PIPE_LAT-1:0] hs_dly_q, vs_dly_q, cs_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y1_q      <= '0;
      c1_q      <= '0;
      pal1_q    <= 1'b0;
      vblank1_q <= 1'b0;
      hs_dly_q  <= '0;
      vs_dly_q  <= '0;
      cs_dly_q  <= '0;
    end else begin
      y1_q      <= y_in;
      c1_q      <= c_in;
      pal1_q    <= pal_en;
      vblank1_q <= vblank;
      hs_dly_q  <= {hs_dly_q[PIPE_LAT-2:0], hsync};
      vs_dly_q  <= {vs_dly_q[PIPE_LAT-2:0], vsync};
      cs_dly_q  <= {cs_dly_q[PIPE_LAT-2:0], csync};
    end
  end

  yc_state_e state2;

  yc_sync_tracker #(
    .BP_CLKS(BP_CLKS)
  ) u_tracker (
    .clk    (clk),
    .reset_n(reset_n),
    .csync_i(cs_dly_q[0]),
    .state_o(state2)
  );

  // Stage 2: luma gain (Q0.8) and signed chroma gain (Q1.7).
  logic [YPROD_W-1:0]        y_prod_c;
  logic signed [DW:0]        cs_c, c_gain_c;
  logic signed [CPROD_W-1:0] c_prod_c;
  yc_s2_t                    s2_d, s2_q;

  assign y_prod_c = YPROD_W'(y1_q) * YPROD_W'(Y_GAIN);
  assign cs_c     = $signed({1'b0, c1_q}) - 9'sd128;
  assign c_gain_c = $signed({1'b0, C_GAIN});
  assign c_prod_c = CPROD_W'(cs_c) * CPROD_W'(c_gain_c);

  always_comb begin
    s2_d        = '0;
    s2_d.y_scl  = y_prod_c[YPROD_W-1:DW];
    s2_d.cs_scl = CS_W'(c_prod_c >>> 7);
    s2_d.pal_en = pal1_q;
    s2_d.vblank = vblank1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_q <= '0;
    end else begin
      s2_q <= s2_d;
    end
  end

  // Stage 3: pick the luma level for the line region, gate chroma, sum and clamp.
  logic signed [SUM_W-1:0] luma_c, cs_eff_c;
  logic                    chroma_on_c;
  logic [DW-1:0]           cvbs_d, luma_d, chroma_d;
  logic [DW-1:0]           cvbs_q, luma_q, chroma_q;

  always_comb begin
    luma_c      = SUM_W'(BLANK_LVL);
    chroma_on_c = 1'b0;
    unique case (state2)
      ST_SYNC:  luma_c = SUM_W'(SYNC_LVL);
      ST_PORCH: chroma_on_c = 1'b1;
      ST_ACTIVE: begin
        if (!s2_q.vblank) begin
          luma_c      = SUM_W'(BLANK_LVL) + SUM_W'(s2_q.y_scl)
                      + (s2_q.pal_en ? SUM_W'(0) : SUM_W'(SETUP_LVL));
          chroma_on_c = 1'b1;
        end
      end
      default: ;
    endcase
    cs_eff_c = chroma_on_c ? SUM_W'($signed(s2_q.cs_scl)) : SUM_W'(0);
    cvbs_d   = clamp8(luma_c + cs_eff_c);
    luma_d   = clamp8(luma_c);
    chroma_d = clamp8(C_MID + cs_eff_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cvbs_q   <= BLANK_LVL;
      luma_q   <= BLANK_LVL;
      chroma_q <= 8'd128;
    end else begin
      cvbs_q   <= cvbs_d;
      luma_q   <= luma_d;
      chroma_q <= chroma_d;
    end
  end

  assign cvbs     = cvbs_q;
  assign luma_s   = luma_q;
  assign chroma_s = chroma_q;
  assign hsync_o  = hs_dly_q[PIPE_LAT-1];
  assign vsync_o  = vs_dly_q[PIPE_LAT-1];
  assign csync_o  = cs_dly_q[PIPE_LAT-1];

endmodule
